// File: rtl/pipe_hazard_ctrl_if.sv
// Decode-side hazard bus. It carries the ID-stage instruction attributes and
// the EX branch-resolution strobe into the hazard controller, and carries the
// stall, flush, bubble and forwarding-select controls back to the pipeline.
//   master : pipeline / decode side (drives i_*, receives o_*)
//   slave  : pipe_hazard_ctrl      (receives i_*, drives o_*)
interface pipe_hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int DEPTH  = 3,
  parameter int FWD_W  = $clog2(DEPTH + 1)
);
  logic              i_id_valid;
  logic [REG_AW-1:0] i_id_rs1;
  logic [REG_AW-1:0] i_id_rs2;
  logic              i_id_use_rs1;
  logic              i_id_use_rs2;
  logic [REG_AW-1:0] i_id_rd;
  logic              i_id_we;
  logic              i_id_load;
  logic              i_id_mc;
  logic              i_ex_branch_taken;
  logic              o_stall_if;
  logic              o_stall_id;
  logic              o_flush_id;
  logic              o_bubble_ex;
  logic [FWD_W-1:0]  o_fwd_a;
  logic [FWD_W-1:0]  o_fwd_b;
  logic              o_mc_busy;

  modport master (
    output i_id_valid, i_id_rs1, i_id_rs2, i_id_use_rs1, i_id_use_rs2,
           i_id_rd, i_id_we, i_id_load, i_id_mc, i_ex_branch_taken,
    input  o_stall_if, o_stall_id, o_flush_id, o_bubble_ex,
           o_fwd_a, o_fwd_b, o_mc_busy
  );

  modport slave (
    input  i_id_valid, i_id_rs1, i_id_rs2, i_id_use_rs1, i_id_use_rs2,
           i_id_rd, i_id_we, i_id_load, i_id_mc, i_ex_branch_taken,
    output o_stall_if, o_stall_id, o_flush_id, o_bubble_ex,
           o_fwd_a, o_fwd_b, o_mc_busy
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and stall controller for the in-order RV32IC pipeline.
// A scoreboard of DEPTH entries (1=EX, 2=MEM, 3=WB, ...) records what each
// stage after ID will write; the ID operands are compared against it to pick
// forwarding sources and detect load-use hazards. A down-counter holds EX for
// multi-cycle operations.
// Ports:
//   i_clk    rising-edge clock
//   i_reset  asynchronous active-low reset
//   bus      pipe_hazard_ctrl_if.slave (ID attributes in, pipeline controls out)
//
// mode      | meaning
// ----------+----------------------------------------------------------
// mc busy   | mc_cnt != 0: EX held, IF/ID held, MEM gets a bubble
// flush     | taken branch in EX: IF/ID cleared, NOP into ID/EX
// load-use  | ID reads a load's rd in EX: one-cycle stall + NOP into ID/EX
// normal    | ID instruction advances into EX, scoreboard shifts
module pipe_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int DEPTH  = 3,
  parameter int MC_LAT = 4,
  parameter int FWD_W  = $clog2(DEPTH + 1)
) (
  input logic              i_clk,
  input logic              i_reset,
  pipe_hazard_ctrl_if.slave bus
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              we;
    logic              load;
  } entry_t;

  entry_t [DEPTH:1] sb_q, sb_d;
  logic [3:0]       mc_cnt_q, mc_cnt_d;

  logic [DEPTH:1]   hit_a, hit_b;
  logic [FWD_W-1:0] near_a, near_b;
  logic             mc_busy, lu, br;

  always_comb begin
    hit_a = '0;
    hit_b = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      hit_a[k] = sb_q[k].valid && sb_q[k].we && (sb_q[k].rd == bus.i_id_rs1) &&
                 (bus.i_id_rs1 != '0) && bus.i_id_valid && bus.i_id_use_rs1;
      hit_b[k] = sb_q[k].valid && sb_q[k].we && (sb_q[k].rd == bus.i_id_rs2) &&
                 (bus.i_id_rs2 != '0) && bus.i_id_valid && bus.i_id_use_rs2;
    end
  end

  // Scan oldest to youngest so the nearest matching stage is left standing.
  always_comb begin
    near_a = '0;
    near_b = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (hit_a[k]) near_a = FWD_W'(k);
      if (hit_b[k]) near_b = FWD_W'(k);
    end
  end

  assign mc_busy = (mc_cnt_q != 4'd0);
  assign br      = bus.i_ex_branch_taken;
  assign lu      = (hit_a[1] || hit_b[1]) && sb_q[1].load;

  // Outputs are forced low while reset is held, including the paths that
  // depend only on the branch input.
  always_comb begin
    bus.o_mc_busy   = i_reset && mc_busy;
    bus.o_stall_if  = i_reset && (mc_busy || (!br && lu));
    bus.o_stall_id  = i_reset && (mc_busy || (!br && lu));
    bus.o_flush_id  = i_reset && !mc_busy && br;
    bus.o_bubble_ex = i_reset && !mc_busy && (br || lu);
    // A load in EX has no data yet, so that operand must not select stage 1.
    bus.o_fwd_a     = (!i_reset || (hit_a[1] && sb_q[1].load)) ? '0 : near_a;
    bus.o_fwd_b     = (!i_reset || (hit_b[1] && sb_q[1].load)) ? '0 : near_b;
  end

  always_comb begin
    sb_d     = sb_q;
    mc_cnt_d = mc_cnt_q;
    if (mc_busy) begin
      // EX frozen; MEM receives a bubble while older stages keep draining.
      mc_cnt_d = mc_cnt_q - 4'd1;
      sb_d[2]  = '0;
      for (int k = 3; k <= DEPTH; k++) sb_d[k] = sb_q[k-1];
    end else begin
      for (int k = 2; k <= DEPTH; k++) sb_d[k] = sb_q[k-1];
      if (br || lu) begin
        sb_d[1] = '0;
      end else begin
        sb_d[1] = '{valid: bus.i_id_valid, rd: bus.i_id_rd,
                    we: bus.i_id_we, load: bus.i_id_load};
        // Loaded with MC_LAT-1: the final EX cycle runs with the counter at 0.
        if (bus.i_id_valid && bus.i_id_mc) mc_cnt_d = 4'(MC_LAT - 1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      sb_q     <= '0;
      mc_cnt_q <= '0;
    end else begin
      sb_q     <= sb_d;
      mc_cnt_q <= mc_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;
  localparam int REG_AW = 5;
  localparam int DEPTH  = 3;
  localparam int MC_LAT = 4;
  localparam int FWD_W  = $clog2(DEPTH + 1);

  logic clk;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;

  pipe_hazard_ctrl_if #(.REG_AW(REG_AW), .DEPTH(DEPTH), .FWD_W(FWD_W)) bus ();

  pipe_hazard_ctrl #(.REG_AW(REG_AW), .DEPTH(DEPTH), .MC_LAT(MC_LAT), .FWD_W(FWD_W)) dut (
    .i_clk  (clk),
    .i_reset(rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a queue of in-flight instructions, index 0 = EX.
  typedef struct {
    bit v;
    int rd;
    bit we;
    bit ld;
  } ent_t;

  ent_t stg[$];
  int   occ;   // EX cycles the multi-cycle op still owns, counting the current one

  bit t_v, t_u1, t_u2, t_we, t_ld, t_mc, t_br;
  int t_rs1, t_rs2, t_rd;

  logic e_stall, e_flush, e_bub, e_busy;
  int   e_fa, e_fb;
  bit   m_lu, m_busy;

  function automatic ent_t empty_ent();
    ent_t e;
    e.v = 0; e.rd = 0; e.we = 0; e.ld = 0;
    return e;
  endfunction

  task automatic model_reset();
    stg.delete();
    for (int i = 0; i < DEPTH; i++) stg.push_back(empty_ent());
    occ = 0;
  endtask

  function automatic bit writes(int k, int rs, bit use_);
    return t_v && use_ && rs != 0 && stg[k].v && stg[k].we && stg[k].rd == rs;
  endfunction

  function automatic int m_fwd(int rs, bit use_);
    for (int k = 0; k < DEPTH; k++)
      if (writes(k, rs, use_)) return (k == 0 && stg[0].ld) ? 0 : k + 1;
    return 0;
  endfunction

  task automatic model_eval();
    m_lu    = stg[0].ld && (writes(0, t_rs1, t_u1) || writes(0, t_rs2, t_u2));
    m_busy  = occ > 1;
    e_busy  = m_busy;
    e_stall = m_busy || (!t_br && m_lu);
    e_flush = !m_busy && t_br;
    e_bub   = !m_busy && (t_br || m_lu);
    e_fa    = m_fwd(t_rs1, t_u1);
    e_fb    = m_fwd(t_rs2, t_u2);
  endtask

  task automatic model_advance();
    ent_t cur;
    cur.v = t_v; cur.rd = t_rd; cur.we = t_we; cur.ld = t_ld;
    if (m_busy) begin
      occ--;
      stg.insert(1, empty_ent());
      void'(stg.pop_back());
    end else begin
      stg.push_front((t_br || m_lu) ? empty_ent() : cur);
      void'(stg.pop_back());
      if (occ > 0) occ--;
      if (!t_br && !m_lu && t_v && t_mc) occ = MC_LAT;
    end
  endtask

  task automatic chk1(string tag, logic obs, logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chkf(string tag, logic [FWD_W-1:0] obs, int exp);
    n_assert++;
    assert (obs === FWD_W'(exp)) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk1("stall_if", bus.o_stall_if, e_stall);
    chk1("stall_id", bus.o_stall_id, e_stall);
    chk1("flush_id", bus.o_flush_id, e_flush);
    chk1("bubble_ex", bus.o_bubble_ex, e_bub);
    chk1("mc_busy", bus.o_mc_busy, e_busy);
    chkf("fwd_a", bus.o_fwd_a, e_fa);
    chkf("fwd_b", bus.o_fwd_b, e_fb);
  endtask

  task automatic check_zero(string tag);
    chk1({tag, "_stall_if"}, bus.o_stall_if, 1'b0);
    chk1({tag, "_stall_id"}, bus.o_stall_id, 1'b0);
    chk1({tag, "_flush_id"}, bus.o_flush_id, 1'b0);
    chk1({tag, "_bubble_ex"}, bus.o_bubble_ex, 1'b0);
    chk1({tag, "_mc_busy"}, bus.o_mc_busy, 1'b0);
    chkf({tag, "_fwd_a"}, bus.o_fwd_a, 0);
    chkf({tag, "_fwd_b"}, bus.o_fwd_b, 0);
  endtask

  task automatic apply();
    bus.i_id_valid        = t_v;
    bus.i_id_rs1          = REG_AW'(t_rs1);
    bus.i_id_rs2          = REG_AW'(t_rs2);
    bus.i_id_use_rs1      = t_u1;
    bus.i_id_use_rs2      = t_u2;
    bus.i_id_rd           = REG_AW'(t_rd);
    bus.i_id_we           = t_we;
    bus.i_id_load         = t_ld;
    bus.i_id_mc           = t_mc;
    bus.i_ex_branch_taken = t_br;
  endtask

  // Present one ID instruction, then compare all outputs against the model.
  task automatic issue(bit v, int rs1, int rs2, bit u1, bit u2, int rd,
                       bit we, bit ld, bit mc, bit br);
    t_v = v; t_rs1 = rs1; t_rs2 = rs2; t_u1 = u1; t_u2 = u2;
    t_rd = rd; t_we = we; t_ld = ld; t_mc = mc; t_br = br;
    apply();
    @(negedge clk);
    model_eval();
    check_model();
  endtask

  task automatic tick();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic nops(int n);
    for (int i = 0; i < n; i++) begin
      issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    model_reset();
    t_v = 0; t_rs1 = 0; t_rs2 = 0; t_u1 = 0; t_u2 = 0;
    t_rd = 0; t_we = 0; t_ld = 0; t_mc = 0; t_br = 1;
    apply();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Producer/consumer distance 1..4
    for (int gap = 0; gap < 4; gap++) begin
      nops(DEPTH);
      issue(1, 1, 2, 1, 1, 5, 1, 0, 0, 0);
      tick();
      nops(gap);
      issue(1, 5, 1, 1, 1, 6, 1, 0, 0, 0);
      chkf("fwd_dist_a", bus.o_fwd_a, (gap < DEPTH) ? gap + 1 : 0);
      chkf("fwd_dist_b", bus.o_fwd_b, 0);
      chk1("fwd_dist_nostall", bus.o_stall_if, 1'b0);
      tick();
    end

    // Load-use: one stall cycle, then forward from MEM
    nops(DEPTH);
    issue(1, 1, 2, 1, 0, 6, 1, 1, 0, 0);
    tick();
    issue(1, 6, 6, 1, 1, 7, 1, 0, 0, 0);
    chk1("lu_stall_if", bus.o_stall_if, 1'b1);
    chk1("lu_stall_id", bus.o_stall_id, 1'b1);
    chk1("lu_bubble", bus.o_bubble_ex, 1'b1);
    chkf("lu_fwd_a", bus.o_fwd_a, 0);
    tick();
    issue(1, 6, 6, 1, 1, 7, 1, 0, 0, 0);
    chk1("lu_after_stall", bus.o_stall_if, 1'b0);
    chkf("lu_after_fwd_a", bus.o_fwd_a, 2);
    chkf("lu_after_fwd_b", bus.o_fwd_b, 2);
    tick();

    // x0 never forwards; nearest of two writers wins
    nops(DEPTH);
    issue(1, 0, 0, 1, 0, 0, 1, 0, 0, 0);
    tick();
    issue(1, 0, 0, 1, 1, 8, 1, 0, 0, 0);
    chkf("x0_fwd_a", bus.o_fwd_a, 0);
    chkf("x0_fwd_b", bus.o_fwd_b, 0);
    tick();
    issue(1, 1, 1, 1, 1, 9, 1, 0, 0, 0);
    tick();
    issue(1, 2, 2, 1, 1, 9, 1, 0, 0, 0);
    tick();
    issue(1, 9, 3, 1, 1, 4, 1, 0, 0, 0);
    chkf("nearest_fwd_a", bus.o_fwd_a, 1);
    tick();

    // Branch flush overrides load-use
    nops(DEPTH);
    issue(1, 1, 2, 1, 0, 6, 1, 1, 0, 0);
    tick();
    issue(1, 6, 6, 1, 1, 7, 1, 0, 0, 1);
    chk1("br_lu_flush", bus.o_flush_id, 1'b1);
    chk1("br_lu_bubble", bus.o_bubble_ex, 1'b1);
    chk1("br_lu_stall_if", bus.o_stall_if, 1'b0);
    tick();
    issue(1, 6, 6, 1, 1, 7, 1, 0, 0, 0);
    chk1("br_after_stall", bus.o_stall_if, 1'b0);
    tick();

    // Multi-cycle op: three busy cycles ignoring branch, then forward from EX
    nops(DEPTH);
    issue(1, 1, 2, 1, 1, 10, 1, 0, 1, 0);
    tick();
    for (int i = 0; i < MC_LAT - 1; i++) begin
      issue(1, 10, 3, 1, 1, 11, 1, 0, 0, 1);
      chk1("mc_busy", bus.o_mc_busy, 1'b1);
      chk1("mc_stall_if", bus.o_stall_if, 1'b1);
      chk1("mc_no_flush", bus.o_flush_id, 1'b0);
      chk1("mc_no_bubble", bus.o_bubble_ex, 1'b0);
      tick();
    end
    issue(1, 10, 3, 1, 1, 11, 1, 0, 0, 0);
    chk1("mc_done_busy", bus.o_mc_busy, 1'b0);
    chk1("mc_done_stall", bus.o_stall_if, 1'b0);
    chkf("mc_done_fwd_a", bus.o_fwd_a, 1);
    tick();

    // Reset in the 2nd busy cycle
    nops(DEPTH);
    issue(1, 1, 2, 1, 1, 10, 1, 0, 1, 0);
    tick();
    issue(1, 10, 3, 1, 1, 11, 1, 0, 0, 0);
    tick();
    issue(1, 10, 3, 1, 1, 11, 1, 0, 0, 1);
    chk1("rst_pre_busy", bus.o_mc_busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check_zero("rst_mid");
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    nops(2);
    issue(1, 10, 3, 1, 1, 11, 1, 0, 0, 0);
    chkf("rst_after_fwd_a", bus.o_fwd_a, 0);
    chk1("rst_after_busy", bus.o_mc_busy, 1'b0);
    chk1("rst_after_stall", bus.o_stall_if, 1'b0);
    tick();

    // Randomized traffic against the model
    for (int n = 0; n < 500; n++) begin
      bit ld;
      ld = ($urandom_range(0, 3) == 0);
      issue($urandom_range(0, 9) != 0, $urandom_range(0, 4), $urandom_range(0, 4),
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            $urandom_range(0, 4), $urandom_range(0, 4) != 0, ld,
            !ld && ($urandom_range(0, 11) == 0), $urandom_range(0, 9) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
